// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, default geometry, accumulator sizing and saturation limits
// for the one-multiplier convolution tap sequencer.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DEF_KH    = 3;
    localparam int DEF_KW    = 3;
    localparam int DEF_IMG_W = 28;

    localparam logic [7:0] SAT_MAX = 8'h7F;
    localparam logic [7:0] SAT_MIN = 8'h80;

    // 16-bit products plus enough headroom to sum every tap without overflow
    function automatic int acc_w(input int kh, input int kw);
        return 16 + $clog2(kh * kw);
    endfunction

endpackage

// File: rtl/conv_tap_sequencer_addr_gen.sv
// conv_addr_gen: row/column tap counters producing pixel and weight read addresses
// for one KHxKW window; addresses read as zero while not advancing.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int KH      = DEF_KH,
    parameter int KW      = DEF_KW,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               adv,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               last_tap
);

    localparam int CW = (KW > 1) ? $clog2(KW) : 1;

    // row_q holds the address of the current row start, so no multiplier is needed
    logic [ADDR_W-1:0]  row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic [WADDR_W-1:0] tap_q, tap_d;
    logic               col_wrap;

    assign col_wrap = col_q == CW'(KW - 1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        tap_d = tap_q;
        if (load) begin
            row_d = base_addr;
            col_d = '0;
            tap_d = '0;
        end else if (adv) begin
            col_d = col_wrap ? '0 : col_q + 1'b1;
            row_d = col_wrap ? row_q + ADDR_W'(IMG_W) : row_q;
            tap_d = tap_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            tap_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            tap_q <= tap_d;
        end
    end

    assign pix_addr = adv ? row_q + ADDR_W'(col_q) : '0;
    assign wgt_addr = adv ? tap_q : '0;
    assign last_tap = tap_q == WADDR_W'(KH * KW - 1);

endmodule

// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: walks a KHxKW window through one shared multiplier and returns a Q1.7
// result over valid/ready. Define CONV_SAT_EN to clamp the result instead of wrapping.
module conv_tap_sequencer
    import conv_pkg::*;
#(
    parameter int KH      = DEF_KH,
    parameter int KW      = DEF_KW,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               busy,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               mem_re,
    input  logic [7:0]         pix_data,
    input  logic [7:0]         wgt_data,
    output logic [7:0]         mult_a,
    output logic [7:0]         mult_b,
    input  logic [15:0]        mult_m,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int ACC_W = acc_w(KH, KW);

    state_t                   state_q, state_d;
    logic                     re_q, re_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]               out_data_q, out_data_d;
    logic [7:0]               result;
    logic                     accept, run, last_tap;

`ifdef CONV_SAT_EN
    localparam logic signed [ACC_W-8:0] SH_MAX = (ACC_W - 7)'(127);
    localparam logic signed [ACC_W-8:0] SH_MIN = (ACC_W - 7)'(-128);
    logic signed [ACC_W-8:0] acc_sh;
`endif

    assign accept    = (state_q == IDLE) && start;
    assign run       = state_q == RUN;
    assign mem_re    = run;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign out_data  = out_data_q;
    assign mult_a    = pix_data;
    assign mult_b    = wgt_data;

    conv_addr_gen #(
        .KH      (KH),
        .KW      (KW),
        .IMG_W   (IMG_W),
        .ADDR_W  (ADDR_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .adv       (run),
        .base_addr (base_addr),
        .pix_addr  (pix_addr),
        .wgt_addr  (wgt_addr),
        .last_tap  (last_tap)
    );

    always_comb begin
        state_d = state_q;
        re_d    = run;
        acc_d   = accept ? '0 : re_q ? acc_q + ACC_W'($signed(mult_m)) : acc_q;
`ifdef CONV_SAT_EN
        acc_sh  = acc_d[ACC_W-1:7];
        result  = (acc_sh > SH_MAX) ? SAT_MAX : (acc_sh < SH_MIN) ? SAT_MIN : acc_d[14:7];
`else
        result  = acc_d[14:7];
`endif
        // DRAIN folds in the final product, so the result is taken from acc_d here
        out_data_d = (state_q == DRAIN) ? result : out_data_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_tap ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            re_q       <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            re_q       <= re_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
